// File: rtl/dca_neugemm_mlsu_dispatcher.sv
// -----------------------------------------------------------------------------
// dca_neugemm_mlsu_dispatcher
//
// Instruction dispatcher for a NeuGEMM MMIO-X core with NUM_CH matrix LSU
// channels. Pops control words from the instruction FIFO, routes LSU
// instructions to one channel each, tracks outstanding work per channel,
// implements fence and clear, and writes per-channel completion records to
// the log FIFO.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   core_config          1 = new instruction pops allowed
//   core_status          {perf[15:0], outst_sum[7:0], 3'b0, err_log_ovf,
//                         err_unexp_fin, err_bad_ch, fence_wait, busy}
//   clear_request        level request to flush dispatcher state
//   clear_finish         1-cycle pulse when the flush completes
//   inst_fifo_*          show-ahead instruction FIFO read side
//                        word = {opcode(0 issue/1 fence), ch id, payload}
//   operation_finish     1-cycle pulse when a fence retires
//   log_fifo_*           log FIFO write side; record =
//                        {16'h0, 4'h0, ch[3:0], 4'h0, outst_after[3:0]}
//   ch_inst_*            per-channel valid/ready instruction handshake
//   ch_execute_finish    per-channel completion pulses
//   ch_busy              per-channel busy levels
//
// Configuration
//   DCA_MLSU_DISPATCH_PERF_EN  when defined, core_status[31:16] is a
//                              saturating count of ISSUE stall cycles;
//                              otherwise that field is tied to zero.
// -----------------------------------------------------------------------------
module dca_neugemm_mlsu_dispatcher #(
  parameter int NUM_CH      = 3,
  parameter int BW_LSU_INST = 64,
  parameter int BW_CH       = 3,
  parameter int MAX_OUTST   = 4,
  parameter int BW_INST     = BW_LSU_INST + BW_CH + 1,
  parameter int BW_LOG      = 32,
  parameter int BW_STATUS   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          core_config,
  output logic [BW_STATUS-1:0]          core_status,
  input  logic                          clear_request,
  output logic                          clear_finish,
  input  logic                          inst_fifo_rready,
  input  logic [BW_INST-1:0]            inst_fifo_rdata,
  output logic                          inst_fifo_rrequest,
  output logic                          operation_finish,
  input  logic                          log_fifo_wready,
  output logic                          log_fifo_wrequest,
  output logic [BW_LOG-1:0]             log_fifo_wdata,
  output logic [NUM_CH-1:0]             ch_inst_wvalid,
  output logic [NUM_CH*BW_LSU_INST-1:0] ch_inst_wdata,
  input  logic [NUM_CH-1:0]             ch_inst_wready,
  input  logic [NUM_CH-1:0]             ch_execute_finish,
  input  logic [NUM_CH-1:0]             ch_busy
);

  localparam int BW_OUTST = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, FENCE, CLEAR} state_t;

  state_t                 state, state_next;
  logic [BW_CH-1:0]       ch_q;
  logic [BW_LSU_INST-1:0] payload_q;
  logic [BW_OUTST-1:0]    outst      [NUM_CH];
  logic [BW_OUTST-1:0]    outst_next [NUM_CH];
  logic [BW_OUTST-1:0]    log_cnt    [NUM_CH];
  logic [NUM_CH-1:0]      outst_nz;
  logic [NUM_CH-1:0]      pending, pending_next;
  logic                   err_bad_ch, err_unexp_fin, err_log_ovf;

  logic [NUM_CH-1:0]      ch_sel;
  logic                   ch_ok, ch_full;
  logic [NUM_CH-1:0]      issue_acc;
  logic [7:0]             outst_sum;
  logic                   fence_done, clear_done;

  logic [NUM_CH-1:0]      log_sel;
  logic [3:0]             log_ch;
  logic [BW_OUTST-1:0]    log_val;
  logic                   log_any;
  logic [15:0]            perf_val;
  logic [31:0]            status_w;

  // ---------------------------------------------------------------------------
  // Decode of the latched word and outstanding-count summary
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ch_sel    = '0;
    ch_full   = 1'b0;
    outst_sum = '0;
    outst_nz  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_sel[c]   = (int'(ch_q) == c);
      outst_nz[c] = (outst[c] != '0);
      if (ch_sel[c] && outst[c] == BW_OUTST'(MAX_OUTST)) ch_full = 1'b1;
      outst_sum = outst_sum + 8'(outst[c]);
    end
    ch_ok = (int'(ch_q) < NUM_CH);
  end

  assign fence_done = (outst_sum == '0) && (ch_busy == '0);
  assign clear_done = (state == CLEAR) && (ch_busy == '0);
  assign issue_acc  = ch_inst_wvalid & ch_inst_wready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (clear_request)
          state_next = CLEAR;
        else if (core_config && inst_fifo_rready)
          state_next = inst_fifo_rdata[BW_INST-1] ? FENCE : ISSUE;
      end
      // A bad channel id drops the word; otherwise leave only on acceptance.
      ISSUE:   if (!ch_ok || (issue_acc != '0)) state_next = IDLE;
      FENCE:   if (fence_done) state_next = IDLE;
      CLEAR:   if (clear_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    inst_fifo_rrequest = 1'b0;
    ch_inst_wvalid     = '0;
    operation_finish   = 1'b0;
    clear_finish       = 1'b0;
    case (state)
      IDLE:    inst_fifo_rrequest = !rst && !clear_request && core_config && inst_fifo_rready;
      ISSUE:   if (ch_ok && !ch_full) ch_inst_wvalid = ch_sel;
      FENCE:   operation_finish = fence_done;
      CLEAR:   clear_finish = clear_done;
      default: ;
    endcase
  end

  // Every slice carries the latched payload; only the selected channel's
  // valid is raised, and the payload stays stable until it is accepted.
  assign ch_inst_wdata = {NUM_CH{payload_q}};

  // ---------------------------------------------------------------------------
  // Outstanding counters, pending-log bits
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      outst_next[c] = outst[c];
      // Simultaneous issue and finish cancel; a finish at zero saturates.
      if (issue_acc[c] && !ch_execute_finish[c])
        outst_next[c] = outst[c] + 1'b1;
      else if (!issue_acc[c] && ch_execute_finish[c] && outst_nz[c])
        outst_next[c] = outst[c] - 1'b1;
    end
  end

  // Lowest pending channel wins the log FIFO.
  always_comb begin
    log_sel = '0;
    log_ch  = '0;
    log_val = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (pending[c]) begin
        log_sel = '0;
        log_sel[c] = 1'b1;
        log_ch  = 4'(c);
        log_val = log_cnt[c];
      end
    end
  end

  assign log_any           = (pending != '0);
  assign log_fifo_wrequest = !rst && log_any && log_fifo_wready;
  assign log_fifo_wdata    = log_fifo_wrequest ?
                             BW_LOG'({16'h0, 4'h0, log_ch, 4'h0, log_val}) : '0;

  // A finish on a channel whose record is still pending merges into it.
  assign pending_next = (pending & ~(log_fifo_wrequest ? log_sel : '0)) | ch_execute_finish;

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q          <= '0;
      payload_q     <= '0;
      pending       <= '0;
      err_bad_ch    <= 1'b0;
      err_unexp_fin <= 1'b0;
      err_log_ovf   <= 1'b0;
      // NOTE: these small per-channel arrays are control state, not storage,
      // so each entry is reset explicitly.
      for (int c = 0; c < NUM_CH; c++) begin
        outst[c]   <= '0;
        log_cnt[c] <= '0;
      end
    end else begin
      if (inst_fifo_rrequest) begin
        ch_q      <= inst_fifo_rdata[BW_INST-2 -: BW_CH];
        payload_q <= inst_fifo_rdata[BW_LSU_INST-1:0];
      end
      if (clear_done) begin
        pending       <= '0;
        err_bad_ch    <= 1'b0;
        err_unexp_fin <= 1'b0;
        err_log_ovf   <= 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
          outst[c]   <= '0;
          log_cnt[c] <= '0;
        end
      end else begin
        pending <= pending_next;
        for (int c = 0; c < NUM_CH; c++) begin
          outst[c] <= outst_next[c];
          if (ch_execute_finish[c]) log_cnt[c] <= outst_next[c];
        end
        if (state == ISSUE && !ch_ok)               err_bad_ch    <= 1'b1;
        if ((ch_execute_finish & ~outst_nz) != '0)  err_unexp_fin <= 1'b1;
        if ((ch_execute_finish & pending) != '0)    err_log_ovf   <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional stall-cycle counter
  // ---------------------------------------------------------------------------
`ifdef DCA_MLSU_DISPATCH_PERF_EN
  logic [15:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear_done)
      perf_cnt <= '0;
    else if (state == ISSUE && ch_ok && issue_acc == '0 && perf_cnt != 16'hFFFF)
      perf_cnt <= perf_cnt + 16'd1;
  end

  assign perf_val = perf_cnt;
`else
  assign perf_val = '0;
`endif

  // ---------------------------------------------------------------------------
  // Status word
  // ---------------------------------------------------------------------------
  assign status_w = {perf_val, outst_sum, 3'b000, err_log_ovf, err_unexp_fin,
                     err_bad_ch, (state == FENCE),
                     (state != IDLE) || (outst_sum != '0)};
  assign core_status = BW_STATUS'(status_w);

endmodule
